// File: rtl/wired_icache_refill_if.sv
// Bundle of the refill controller's pipeline request/response port, memory read
// channel and SRAM write ports. The controller connects through "master"; the
// surrounding pipeline/memory environment uses "slave".
interface wired_icache_refill_if #(
    parameter int WAY_NUM = 4,
    parameter int TAG_W   = 20
);
    logic                       req_valid_i;
    logic                       req_ready_o;
    logic [31:0]                req_paddr_i;
    logic                       req_uncached_i;
    logic [1:0]                 req_size_i;
    logic [WAY_NUM-1:0]         req_way_valid_i;
    logic                       kill_i;
    logic                       resp_valid_o;
    logic [63:0]                resp_rdata_o;
    logic                       resp_err_o;
    logic                       ar_valid_o;
    logic                       ar_ready_i;
    logic [31:0]                ar_addr_o;
    logic [7:0]                 ar_len_o;
    logic [2:0]                 ar_size_o;
    logic                       r_valid_i;
    logic                       r_ready_o;
    logic [63:0]                r_data_i;
    logic                       r_last_i;
    logic [1:0]                 r_resp_i;
    logic                       d_we_o;
    logic [$clog2(WAY_NUM)-1:0] d_way_o;
    logic [11:0]                d_addr_o;
    logic [63:0]                d_wdata_o;
    logic [WAY_NUM-1:0]         t_we_o;
    logic [11:0]                t_addr_o;
    logic [TAG_W:0]             t_wdata_o;

    modport master (
        input  req_valid_i, req_paddr_i, req_uncached_i, req_size_i, req_way_valid_i, kill_i,
        input  ar_ready_i, r_valid_i, r_data_i, r_last_i, r_resp_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, r_ready_o,
        output d_we_o, d_way_o, d_addr_o, d_wdata_o, t_we_o, t_addr_o, t_wdata_o
    );

    modport slave (
        output req_valid_i, req_paddr_i, req_uncached_i, req_size_i, req_way_valid_i, kill_i,
        output ar_ready_i, r_valid_i, r_data_i, r_last_i, r_resp_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, r_ready_o,
        input  d_we_o, d_way_o, d_addr_o, d_wdata_o, t_we_o, t_addr_o, t_wdata_o
    );
endinterface

// File: rtl/wired_icache_refill.sv
// Instruction-cache miss / uncached-fetch controller. Takes one request at a
// time, chooses a victim way, reads a full line (or a single uncached beat) from
// memory, streams cached beats into the data SRAM, commits the tag on a clean
// fill and hands the requested 64-bit word back to the fetch pipeline.
module wired_icache_refill #(
    parameter int WAY_NUM    = 4,
    parameter int LINE_BEATS = 2,
    parameter int TAG_W      = 20
) (
    input logic                   clk,
    input logic                   rst_n,
    wired_icache_refill_if.master bus
);
    localparam int VW = $clog2(WAY_NUM);
    localparam int CW = $clog2(LINE_BEATS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [31:2]     r_paddr;
    logic            r_uncached;
    logic [1:0]      r_size;
    logic [VW-1:0]   r_victim;
    logic [VW-1:0]   r_vptr;
    logic            r_kill;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic [63:0]     r_beat;
    logic [63:0]     r_respHold;

    logic [VW-1:0]   w_victim;
    logic            w_accept;
    logic            w_capture;
    logic            w_tagWrite;
    logic            w_respValid;
    logic            w_unused;

    // Byte-offset bits below a 4-byte boundary never reach the bus
    assign w_unused    = ^bus.req_paddr_i[1:0];

    assign w_accept    = (r_state == S_IDLE) && bus.req_valid_i;
    assign w_capture   = r_uncached || (r_cnt == r_paddr[3 +: CW]);
    assign w_tagWrite  = (r_state == S_DONE) && !r_uncached && !r_err;
    assign w_respValid = (r_state == S_DONE) && !(r_kill || bus.kill_i);

    // Victim choice: fill the lowest empty way first, otherwise round-robin pointer
    always_comb begin
        w_victim = r_vptr;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (!bus.req_way_valid_i[i]) w_victim = VW'(i);
        end
    end

    // Request / line-read / commit sequencing; the bus and SRAM fill always finish, kill only hides the response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_paddr    <= '0;
            r_uncached <= 1'b0;
            r_size     <= '0;
            r_victim   <= '0;
            r_vptr     <= '0;
            r_kill     <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_beat     <= '0;
            r_respHold <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_paddr    <= bus.req_paddr_i[31:2];
                        r_uncached <= bus.req_uncached_i;
                        r_size     <= bus.req_size_i;
                        r_victim   <= w_victim;
                        r_kill     <= bus.kill_i;
                        r_cnt      <= '0;
                        r_err      <= 1'b0;
                        r_state    <= S_AR;
                    end
                end
                S_AR: begin
                    if (bus.kill_i) r_kill <= 1'b1;
                    if (bus.ar_ready_i) r_state <= S_R;
                end
                S_R: begin
                    if (bus.kill_i) r_kill <= 1'b1;
                    if (bus.r_valid_i) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_capture) r_beat <= bus.r_data_i;
                        if (|bus.r_resp_i) r_err <= 1'b1;
                        if (bus.r_last_i) r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_tagWrite) r_vptr <= r_vptr + 1'b1;
                    if (w_respValid) r_respHold <= r_beat;
                    r_kill  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output decode from the registered state; beat writes and response gating follow the live bus inputs
    always_comb begin
        bus.req_ready_o = (r_state == S_IDLE);

        bus.ar_valid_o = (r_state == S_AR);
        bus.ar_addr_o  = '0;
        bus.ar_len_o   = '0;
        bus.ar_size_o  = '0;
        if (r_state == S_AR) begin
            if (r_uncached) begin
                bus.ar_addr_o = {r_paddr[31:2], 2'b00};
                bus.ar_len_o  = 8'd0;
                bus.ar_size_o = {1'b0, r_size};
            end else begin
                bus.ar_addr_o = {r_paddr[31:4], 4'b0000};
                bus.ar_len_o  = 8'(LINE_BEATS - 1);
                bus.ar_size_o = 3'd3;
            end
        end

        bus.r_ready_o = (r_state == S_R);

        bus.d_we_o    = (r_state == S_R) && bus.r_valid_i && !r_uncached;
        bus.d_way_o   = '0;
        bus.d_addr_o  = '0;
        bus.d_wdata_o = '0;
        if (bus.d_we_o) begin
            bus.d_way_o   = r_victim;
            bus.d_addr_o  = {r_paddr[11:4], r_cnt, 3'b000};
            bus.d_wdata_o = bus.r_data_i;
        end

        bus.t_we_o    = '0;
        bus.t_addr_o  = '0;
        bus.t_wdata_o = '0;
        if (w_tagWrite) begin
            bus.t_we_o[r_victim] = 1'b1;
            bus.t_addr_o         = {r_paddr[11:4], 4'b0000};
            bus.t_wdata_o        = {1'b1, r_paddr[31:32-TAG_W]};
        end

        bus.resp_valid_o = w_respValid;
        bus.resp_rdata_o = w_respValid ? r_beat : r_respHold;
        bus.resp_err_o   = w_respValid && r_err;
    end
endmodule

// File: tb/tb_wired_icache_refill.sv
// Self-checking bench for wired_icache_refill: a directed table of fetch
// transactions, a mid-operation reset sequence, and randomized transactions, all
// checked against a transaction-level model of victim choice, bus requests,
// SRAM fills, tag commits and responses.
`timescale 1ns/1ps
module tb_wired_icache_refill;

    logic clk = 1'b0;
    logic rst_n;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    wired_icache_refill_if #(.WAY_NUM(4), .TAG_W(20)) bus ();

    wired_icache_refill #(.WAY_NUM(4), .LINE_BEATS(2), .TAG_W(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] paddr;
        bit          unc;
        logic [1:0]  size;
        logic [3:0]  wv;
        int          arWait;
        int          rGap;
        int          errBeat;
        int          killCycle;
        logic [31:0] expArAddr;
        logic [3:0]  expTagWe;
        bit          expResp;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [1:0]  mVptr = 2'd0;
    logic [63:0] mLastResp = 64'd0;
    vec_t        tbl[13];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one request end to end, acting as the memory slave, then compares against the model
    task automatic applyStimulus(input vec_t v, input logic [63:0] b0, input logic [63:0] b1, input bit handExp);
        int          nBeats, doneCyc, cyc, arLow, beatIdx, gapCnt, nD, nT, nResp, respCyc, readyCyc;
        bit          errd, killed, tagW, arSeen, arDone, arStable;
        logic [1:0]  victim;
        logic [31:0] expAr, obsAr;
        logic [7:0]  expLen, obsLen;
        logic [2:0]  expSize, obsSize;
        logic [63:0] expData, respData, holdData;
        logic        respErr;
        logic [1:0]  dWay[4];
        logic [11:0] dAddr[4];
        logic [63:0] dData[4];
        logic [3:0]  obsTWe;
        logic [11:0] obsTAddr;
        logic [20:0] obsTData;

        nBeats  = v.unc ? 1 : 2;
        doneCyc = 2 + v.arWait + nBeats * (v.rGap + 1);
        victim  = mVptr;
        for (int i = 3; i >= 0; i--) if (!v.wv[i]) victim = 2'(i);
        expAr   = v.unc ? {v.paddr[31:2], 2'b00} : {v.paddr[31:4], 4'b0000};
        expLen  = v.unc ? 8'd0 : 8'd1;
        expSize = v.unc ? {1'b0, v.size} : 3'd3;
        errd    = (v.errBeat >= 0) && (v.errBeat < nBeats);
        killed  = (v.killCycle >= 0);
        tagW    = !v.unc && !errd;
        expData = (v.unc || !v.paddr[3]) ? b0 : b1;

        arLow = 0; beatIdx = 0; gapCnt = 0; nD = 0; nT = 0; nResp = 0;
        respCyc = -1; readyCyc = -1; arSeen = 0; arDone = 0; arStable = 1;
        obsAr = '0; obsLen = '0; obsSize = '0; respData = '0; respErr = 1'b0; holdData = '0;
        obsTWe = '0; obsTAddr = '0; obsTData = '0;
        for (int i = 0; i < 4; i++) begin dWay[i] = '0; dAddr[i] = '0; dData[i] = '0; end

        @(negedge clk);
        bus.req_valid_i     = 1'b1;
        bus.req_paddr_i     = v.paddr;
        bus.req_uncached_i  = v.unc;
        bus.req_size_i      = v.size;
        bus.req_way_valid_i = v.wv;
        bus.kill_i          = (v.killCycle == 0);
        bus.ar_ready_i      = (v.arWait == 0);
        bus.r_valid_i       = 1'b0;
        #1;
        checkOutput("req_ready_idle", bus.req_ready_o, 1'b1);
        cyc = 0;

        while (readyCyc < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.req_valid_i     = 1'b0;
            bus.req_paddr_i     = $urandom;
            bus.req_way_valid_i = 4'($urandom);
            bus.kill_i          = (cyc == v.killCycle);
            bus.ar_ready_i      = (arLow >= v.arWait);
            bus.r_valid_i       = 1'b0;
            bus.r_last_i        = 1'b0;
            bus.r_resp_i        = 2'd0;
            bus.r_data_i        = {$urandom, $urandom};
            if (arDone && beatIdx < nBeats) begin
                if (gapCnt < v.rGap) gapCnt++;
                else begin
                    bus.r_valid_i = 1'b1;
                    bus.r_data_i  = (beatIdx == 0) ? b0 : b1;
                    bus.r_last_i  = (beatIdx == nBeats - 1);
                    bus.r_resp_i  = (beatIdx == v.errBeat) ? 2'd2 : 2'd0;
                end
            end
            #1;
            if (bus.ar_valid_o) begin
                if (!arSeen) begin
                    arSeen = 1; obsAr = bus.ar_addr_o; obsLen = bus.ar_len_o; obsSize = bus.ar_size_o;
                end else if (bus.ar_addr_o !== obsAr || bus.ar_len_o !== obsLen || bus.ar_size_o !== obsSize)
                    arStable = 0;
                if (bus.ar_ready_i) arDone = 1;
                else arLow++;
            end
            if (bus.r_valid_i && bus.r_ready_o) begin beatIdx++; gapCnt = 0; end
            if (bus.d_we_o) begin
                if (nD < 4) begin dWay[nD] = bus.d_way_o; dAddr[nD] = bus.d_addr_o; dData[nD] = bus.d_wdata_o; end
                nD++;
            end
            if (|bus.t_we_o) begin
                nT++; obsTWe = bus.t_we_o; obsTAddr = bus.t_addr_o; obsTData = bus.t_wdata_o;
            end
            if (bus.resp_valid_o) begin
                nResp++; respCyc = cyc; respData = bus.resp_rdata_o; respErr = bus.resp_err_o;
            end
            if (bus.req_ready_o) begin readyCyc = cyc; holdData = bus.resp_rdata_o; end
        end
        bus.kill_i = 1'b0;

        checkOutput("ar_addr", obsAr, expAr);
        checkOutput("ar_len", obsLen, expLen);
        checkOutput("ar_size", obsSize, expSize);
        checkOutput("ar_stable", arStable, 1'b1);
        checkOutput("d_we_count", nD, v.unc ? 0 : 2);
        if (!v.unc) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("d_way%0d", i), dWay[i], victim);
                checkOutput($sformatf("d_addr%0d", i), dAddr[i], {v.paddr[11:4], 1'(i), 3'b000});
                checkOutput($sformatf("d_wdata%0d", i), dData[i], (i == 0) ? b0 : b1);
            end
        end
        checkOutput("t_we_count", nT, tagW);
        if (tagW) begin
            checkOutput("t_we", obsTWe, 4'b0001 << victim);
            checkOutput("t_addr", obsTAddr, {v.paddr[11:4], 4'b0000});
            checkOutput("t_wdata", obsTData, {1'b1, v.paddr[31:12]});
        end
        checkOutput("resp_count", nResp, !killed);
        if (!killed) begin
            checkOutput("resp_rdata", respData, expData);
            checkOutput("resp_err", respErr, errd);
            checkOutput("resp_cycle", respCyc, doneCyc);
            mLastResp = expData;
        end
        checkOutput("ready_cycle", readyCyc, doneCyc + 1);
        checkOutput("rdata_hold", holdData, mLastResp);
        if (handExp) begin
            checkOutput("tbl_ar_addr", obsAr, v.expArAddr);
            checkOutput("tbl_t_we", obsTWe, v.expTagWe);
            checkOutput("tbl_resp", nResp, v.expResp);
        end
        if (tagW) mVptr = mVptr + 2'd1;
    endtask

    // Absolute time limit so a stuck design still ends the run
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset state, directed table, mid-operation reset, random traffic
    initial begin
        vec_t v;
        int   nB, dc;

        tbl[0]  = '{32'h0000_1000, 1'b0, 2'd3, 4'hF, 0, 0, -1, -1, 32'h0000_1000, 4'b0001, 1'b1};
        tbl[1]  = '{32'h0000_2018, 1'b0, 2'd3, 4'hF, 0, 0, -1, -1, 32'h0000_2010, 4'b0010, 1'b1};
        tbl[2]  = '{32'h0000_3020, 1'b0, 2'd3, 4'hF, 0, 0, -1, -1, 32'h0000_3020, 4'b0100, 1'b1};
        tbl[3]  = '{32'h0000_4038, 1'b0, 2'd3, 4'hF, 0, 0, -1, -1, 32'h0000_4030, 4'b1000, 1'b1};
        tbl[4]  = '{32'h0000_5040, 1'b0, 2'd3, 4'hF, 0, 0, -1, -1, 32'h0000_5040, 4'b0001, 1'b1};
        tbl[5]  = '{32'h1C00_0128, 1'b0, 2'd3, 4'b0011, 0, 0, -1, -1, 32'h1C00_0120, 4'b0100, 1'b1};
        tbl[6]  = '{32'h1FE0_01E4, 1'b1, 2'd2, 4'hF, 0, 0, -1, -1, 32'h1FE0_01E4, 4'b0000, 1'b1};
        tbl[7]  = '{32'h0000_6008, 1'b0, 2'd3, 4'hF, 5, 2, -1, -1, 32'h0000_6000, 4'b0100, 1'b1};
        tbl[8]  = '{32'h0000_7000, 1'b0, 2'd3, 4'hF, 0, 0, -1, 2, 32'h0000_7000, 4'b1000, 1'b0};
        tbl[9]  = '{32'h0000_8000, 1'b0, 2'd3, 4'hF, 0, 0, 0, -1, 32'h0000_8000, 4'b0000, 1'b1};
        tbl[10] = '{32'h0000_9008, 1'b0, 2'd3, 4'b1110, 0, 0, -1, 0, 32'h0000_9000, 4'b0001, 1'b0};
        tbl[11] = '{32'h0000_A00C, 1'b1, 2'd3, 4'hF, 0, 0, 0, -1, 32'h0000_A00C, 4'b0000, 1'b1};
        tbl[12] = '{32'h0000_B000, 1'b0, 2'd3, 4'b0000, 0, 0, -1, 4, 32'h0000_B000, 4'b0001, 1'b0};

        rst_n = 1'b0;
        bus.req_valid_i = 1'b0; bus.req_paddr_i = '0; bus.req_uncached_i = 1'b0; bus.req_size_i = '0;
        bus.req_way_valid_i = '0; bus.kill_i = 1'b0; bus.ar_ready_i = 1'b0; bus.r_valid_i = 1'b0;
        bus.r_data_i = '0; bus.r_last_i = 1'b0; bus.r_resp_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", bus.req_ready_o, 1'b1);
        checkOutput("rst_ar_valid", bus.ar_valid_o, 1'b0);
        checkOutput("rst_r_ready", bus.r_ready_o, 1'b0);
        checkOutput("rst_d_we", bus.d_we_o, 1'b0);
        checkOutput("rst_t_we", bus.t_we_o, 4'b0000);
        checkOutput("rst_resp_valid", bus.resp_valid_o, 1'b0);
        checkOutput("rst_resp_rdata", bus.resp_rdata_o, 64'd0);
        checkOutput("rst_resp_err", bus.resp_err_o, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            applyStimulus(tbl[i], 64'hAAAA_0000_0000_0000 | 64'(i), 64'hBBBB_0000_0000_0000 | 64'(i), 1'b1);

        // Reset while the line read is half done: no tag write, victim pointer back to 0
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_paddr_i = 32'h0000_C008; bus.req_uncached_i = 1'b0;
        bus.req_way_valid_i = 4'hF; bus.kill_i = 1'b0; bus.ar_ready_i = 1'b1; bus.r_valid_i = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        #1 checkOutput("mid_ar_valid", bus.ar_valid_o, 1'b1);
        @(negedge clk);
        bus.r_valid_i = 1'b1; bus.r_data_i = 64'h1234_5678_9ABC_DEF0; bus.r_last_i = 1'b0; bus.r_resp_i = 2'd0;
        #1 checkOutput("mid_d_we", bus.d_we_o, 1'b1);
        @(negedge clk);
        bus.r_valid_i = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_rst_ready", bus.req_ready_o, 1'b1);
        checkOutput("mid_rst_t_we", bus.t_we_o, 4'b0000);
        checkOutput("mid_rst_resp", bus.resp_valid_o, 1'b0);
        checkOutput("mid_rst_r_ready", bus.r_ready_o, 1'b0);
        mVptr = 2'd0;
        mLastResp = 64'd0;
        v = '{32'h0000_D010, 1'b0, 2'd3, 4'hF, 0, 0, -1, -1, 32'h0000_D010, 4'b0001, 1'b1};
        applyStimulus(v, 64'hCCCC_0000_0000_0001, 64'hDDDD_0000_0000_0002, 1'b1);

        for (int n = 0; n < 40; n++) begin
            v.paddr     = $urandom;
            v.unc       = ($urandom_range(0, 3) == 0);
            v.size      = $urandom_range(0, 1) ? 2'd3 : 2'd2;
            v.wv        = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            v.arWait    = $urandom_range(0, 3);
            v.rGap      = $urandom_range(0, 2);
            nB          = v.unc ? 1 : 2;
            dc          = 2 + v.arWait + nB * (v.rGap + 1);
            v.errBeat   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nB - 1)) : -1;
            v.killCycle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, dc)) : -1;
            applyStimulus(v, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
